// File: rtl/plab4_net_router_input_buffer_sep.sv
// plab4_net_router_input_buffer_sep
//
// Per-input-port message queue of a ring router. Incoming network messages
// are buffered in a small circular FIFO. The head message, its destination
// field and a valid bit are presented to the router's input terminal
// control. The free-entry count is published for bubble flow control in
// neighbouring routers.
//
// Ports:
//   clk       - sole clock, rising edge
//   reset     - synchronous, active-high; clears pointers and occupancy
//   domain    - static security label; no functional effect
//   in_val    - upstream message valid
//   in_rdy    - queue can accept a message this cycle (not full)
//   in_msg    - incoming message
//   out_val   - head entry valid (not empty)
//   out_rdy   - control stage consumes the head this cycle
//   out_msg   - head message (don't-care while out_val is 0)
//   out_dest  - destination field sliced from out_msg
//   num_free  - p_num_entries minus current occupancy

module plab4_net_router_input_buffer_sep #(
  parameter int p_msg_nbits      = 44,
  parameter int p_num_entries    = 4,
  parameter int p_num_routers    = 8,
  parameter int p_dest_lsb       = 32,
  parameter int p_num_free_nbits = 3,
  localparam int c_dest_nbits    = $clog2(p_num_routers),
  localparam int c_addr_nbits    = $clog2(p_num_entries)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        domain,
  input  logic                        in_val,
  output logic                        in_rdy,
  input  logic [p_msg_nbits-1:0]      in_msg,
  output logic                        out_val,
  input  logic                        out_rdy,
  output logic [p_msg_nbits-1:0]      out_msg,
  output logic [c_dest_nbits-1:0]     out_dest,
  output logic [p_num_free_nbits-1:0] num_free
);

  localparam logic [c_addr_nbits:0] c_full = (c_addr_nbits+1)'(p_num_entries);

  logic [p_msg_nbits-1:0]  storage [p_num_entries];
  logic [c_addr_nbits-1:0] enq_ptr;
  logic [c_addr_nbits-1:0] deq_ptr;
  logic [c_addr_nbits:0]   count;

  logic do_enq;
  logic do_deq;

  // The security label only tags data; it never steers the datapath.
  logic domain_unused;
  assign domain_unused = domain;

  // Ready/valid come purely from registered occupancy, so in_rdy never
  // depends on out_rdy (no bypass when full, no combinational loop).
  assign in_rdy  = (count != c_full);
  assign out_val = (count != '0);
  assign do_enq  = in_val && in_rdy;
  assign do_deq  = out_val && out_rdy;

  assign out_msg  = storage[deq_ptr];
  assign out_dest = out_msg[p_dest_lsb +: c_dest_nbits];
  assign num_free = p_num_free_nbits'(c_full - count);

  // Storage is deliberately not reset; out_val masks stale entries.
  // Writes are suppressed during reset so a reset-cycle enqueue is ignored.
  always_ff @(posedge clk) begin
    if (do_enq && !reset)
      storage[enq_ptr] <= in_msg;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
      count   <= '0;
    end
    else begin
      if (do_enq)
        enq_ptr <= enq_ptr + c_addr_nbits'(1);
      if (do_deq)
        deq_ptr <= deq_ptr + c_addr_nbits'(1);
      case ({do_enq, do_deq})
        2'b10:   count <= count + (c_addr_nbits+1)'(1);
        2'b01:   count <= count - (c_addr_nbits+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_plab4_net_router_input_buffer_sep.sv
// tb_plab4_net_router_input_buffer_sep
//
// Directed bench for the router input buffer (4 entries, 44-bit messages,
// 3-bit destination at bit 32), followed by a randomized backpressure phase
// checked against a simple queue model. Inputs change and outputs are
// sampled on the falling edge.

module tb_plab4_net_router_input_buffer_sep;

  logic        clk = 1'b0;
  logic        reset;
  logic        domain;
  logic        in_val;
  logic        in_rdy;
  logic [43:0] in_msg;
  logic        out_val;
  logic        out_rdy;
  logic [43:0] out_msg;
  logic [2:0]  out_dest;
  logic [2:0]  num_free;

  int errors = 0;
  int checks = 0;

  logic [43:0] model_q [$];

  plab4_net_router_input_buffer_sep dut (
    .clk      (clk),
    .reset    (reset),
    .domain   (domain),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_msg   (in_msg),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_msg  (out_msg),
    .out_dest (out_dest),
    .num_free (num_free)
  );

  always #5 clk = ~clk;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Status outputs checked together.
  task automatic checkStatus(input string tag, input logic exp_rdy,
                             input logic exp_val, input logic [2:0] exp_free);
    checkOutput({tag, ".in_rdy"},   64'(in_rdy),   64'(exp_rdy));
    checkOutput({tag, ".out_val"},  64'(out_val),  64'(exp_val));
    checkOutput({tag, ".num_free"}, 64'(num_free), 64'(exp_free));
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, return at
  // the next falling edge where outputs are stable.
  task automatic applyStimulus(input logic iv, input logic [43:0] msg,
                               input logic ordy);
    in_val  = iv;
    in_msg  = msg;
    out_rdy = ordy;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [43:0] rnd_msg;
    logic        rnd_iv;
    logic        rnd_ordy;
    logic        will_enq;
    logic        will_deq;

    reset   = 1'b1;
    domain  = 1'b0;
    in_val  = 1'b0;
    in_msg  = '0;
    out_rdy = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkStatus("idle", 1'b1, 1'b0, 3'd4);
      applyStimulus(1'b0, '0, 1'b0);
    end

    // Single message; destination 3 sits at bits 34:32
    applyStimulus(1'b1, 44'h003_0003_1234, 1'b1);
    checkStatus("single.c2", 1'b1, 1'b1, 3'd3);
    checkOutput("single.msg",  64'(out_msg),  64'h003_0003_1234);
    checkOutput("single.dest", 64'(out_dest), 64'd3);
    applyStimulus(1'b0, '0, 1'b1);
    checkStatus("single.c3", 1'b1, 1'b0, 3'd4);

    // Fill to full
    applyStimulus(1'b1, 44'd1, 1'b0);
    checkOutput("fill.free1", 64'(num_free), 64'd3);
    applyStimulus(1'b1, 44'd2, 1'b0);
    checkOutput("fill.free2", 64'(num_free), 64'd2);
    applyStimulus(1'b1, 44'd3, 1'b0);
    checkOutput("fill.free3", 64'(num_free), 64'd1);
    applyStimulus(1'b1, 44'd4, 1'b0);
    checkStatus("fill.full", 1'b0, 1'b1, 3'd0);
    checkOutput("fill.head", 64'(out_msg), 64'd1);
    // Full: 5 is refused, 1 is dequeued
    applyStimulus(1'b1, 44'd5, 1'b1);
    checkStatus("fill.after", 1'b1, 1'b1, 3'd1);
    checkOutput("fill.head2", 64'(out_msg), 64'd2);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("fill.head3", 64'(out_msg), 64'd3);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("fill.head4", 64'(out_msg), 64'd4);
    applyStimulus(1'b0, '0, 1'b1);
    checkStatus("fill.drained", 1'b1, 1'b0, 3'd4);

    // Pointer wrap-around: continuous stream
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 44'(100 + i), 1'b1);
      checkStatus("wrap", 1'b1, 1'b1, 3'd3);
      checkOutput("wrap.msg", 64'(out_msg), 64'(100 + i));
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkStatus("wrap.drained", 1'b1, 1'b0, 3'd4);

    // Reset mid-operation with 3 entries queued
    applyStimulus(1'b1, 44'd200, 1'b0);
    applyStimulus(1'b1, 44'd201, 1'b0);
    applyStimulus(1'b1, 44'd202, 1'b0);
    checkStatus("rst.pre", 1'b1, 1'b1, 3'd1);
    reset = 1'b1;
    applyStimulus(1'b1, 44'd999, 1'b1);
    reset = 1'b0;
    checkStatus("rst.post", 1'b1, 1'b0, 3'd4);
    applyStimulus(1'b1, 44'd300, 1'b0);
    checkStatus("rst.enq", 1'b1, 1'b1, 3'd3);
    checkOutput("rst.msg", 64'(out_msg), 64'd300);
    applyStimulus(1'b0, '0, 1'b1);
    checkStatus("rst.drained", 1'b1, 1'b0, 3'd4);

    // Backpressure: random valid/ready against a FIFO model
    model_q.delete();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      checkOutput("bp.out_val",  64'(out_val),  64'(model_q.size() != 0));
      checkOutput("bp.in_rdy",   64'(in_rdy),   64'(model_q.size() < 4));
      checkOutput("bp.num_free", 64'(num_free), 64'(4 - model_q.size()));
      if (model_q.size() != 0)
        checkOutput("bp.out_msg", 64'(out_msg), 64'(model_q[0]));
      rnd_iv   = 1'($urandom_range(0, 1));
      rnd_ordy = 1'($urandom_range(0, 1));
      rnd_msg  = {12'($urandom), 32'($urandom)};
      domain   = 1'($urandom_range(0, 1));
      will_enq = rnd_iv && (model_q.size() < 4);
      will_deq = rnd_ordy && (model_q.size() != 0);
      if (will_deq)
        void'(model_q.pop_front());
      if (will_enq)
        model_q.push_back(rnd_msg);
      applyStimulus(rnd_iv, rnd_msg, rnd_ordy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
